// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - uart_state_e   : transmitter FSM states
//   - PAR_*          : parity mode encodings for the PARITY parameter
//   - UART_DATA_BITS : data bits per frame
//   - calc_parity    : parity bit for a byte under a given parity mode
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones (data + parity) even;
  // odd parity is its inverse.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-rate clock enable for the UART transmitter.
// Ports:
//   clk_in : system clock
//   rst_n  : synchronous active-low reset
//   clear  : restart the count at 0 on the next edge
//   tick   : one-cycle pulse on the last cycle of every CLKS_PER_BIT period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serialiser: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bytes arrive over a valid/ready handshake.
// Ports:
//   clk_in   : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   tx_data  : byte to send, sampled on the accepting edge only
//   tx_valid : upstream has a byte available
//   tx_ready : transmitter idle and able to accept a byte
//   tx       : registered serial line, idle high
//   tx_busy  : a frame is in progress
//   tx_done  : one-cycle pulse as the final stop bit completes
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  uart_state_e                state;
  logic [2:0]                 bit_idx;
  logic [UART_DATA_BITS-1:0]  shift_reg;
  logic                       par_bit;
  logic                       tick;
  logic                       accept;

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);
  assign accept   = rst_n && tx_valid && (state == S_IDLE);

  // Holding the counter cleared while idle makes every frame start at count 0.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .clear (state == S_IDLE),
    .tick  (tick)
  );

  // Data path: byte and its parity captured at acceptance; parity is taken
  // here because the shift register is consumed during DATA.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      shift_reg <= tx_data;
      par_bit   <= calc_parity(tx_data, PARITY);
    end else if (state == S_DATA && tick) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      bit_idx <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            state   <= S_START;
            tx      <= 1'b0;
            bit_idx <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            tx    <= shift_reg[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA_IDX) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // shift_reg[0] is the bit now finishing; the next one is [1].
              tx      <= shift_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (tick) begin
            if (bit_idx == LAST_STOP_IDX) begin
              state   <= S_IDLE;
              bit_idx <= '0;
              tx_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [3:0] vld;
  wire  [3:0] tx_o;
  wire  [3:0] rdy_o;
  wire  [3:0] busy_o;
  wire  [3:0] done_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  // Instance 0: no parity, 1 stop; 1: even parity; 2: odd parity; 3: 2 stops.
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(rdy_o[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(rdy_o[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(rdy_o[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[3]),
    .tx_ready(rdy_o[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

  // Expected line level in cycle k (1 = first cycle after the accepting edge).
  function automatic logic exp_tx(input logic [7:0] b, input int par, input int k);
    int pos;
    int ones;
    pos  = (k - 1) / CPB;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (par != 0 && pos == 9) return (par == 1) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int par, input int stops);
    return CPB * (10 + ((par != 0) ? 1 : 0) + (stops - 1));
  endfunction

  task automatic run_frame(input int idx, input logic [7:0] b, input int par,
                           input int stops, input string name);
    int len;
    len = frame_len(par, stops);
    @(posedge clk_in); #1;
    tx_data  = b;
    vld[idx] = 1'b1;
    @(posedge clk_in); #1;
    vld[idx] = 1'b0;
    tx_data  = 8'h00;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_in);
      n_assert++;
      if (tx_o[idx] !== exp_tx(b, par, k)) begin
        n_fail++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, tx_o[idx], exp_tx(b, par, k));
      end
      n_assert++;
      if ({rdy_o[idx], busy_o[idx], done_o[idx]} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s ready/busy/done cycle %0d: got %b expected 010", name, k,
                 {rdy_o[idx], busy_o[idx], done_o[idx]});
      end
    end
    @(negedge clk_in);
    n_assert++;
    if ({rdy_o[idx], busy_o[idx], done_o[idx], tx_o[idx]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL %s end cycle %0d ready/busy/done/tx: got %b expected 1011", name, len + 1,
               {rdy_o[idx], busy_o[idx], done_o[idx], tx_o[idx]});
    end
    @(negedge clk_in);
    n_assert++;
    if (done_o[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done width: got %b expected 0", name, done_o[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tx_data = 8'h5A;
    vld     = 4'b0001;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if ({rdy_o[i], busy_o[i], done_o[i], tx_o[i]} !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_state inst %0d ready/busy/done/tx: got %b expected 1001", i,
                 {rdy_o[i], busy_o[i], done_o[i], tx_o[i]});
      end
    end
    @(posedge clk_in); #1;
    vld   = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk_in);
    n_assert++;
    if (busy_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake_ignored busy: got %b expected 0", busy_o[0]);
    end
  endtask

  task automatic test_basic();
    run_frame(0, 8'hA5, 0, 1, "basic_a5");
  endtask

  task automatic test_parity();
    run_frame(1, 8'hA5, 1, 1, "even_a5");
    run_frame(2, 8'hA5, 2, 1, "odd_a5");
    run_frame(1, 8'h07, 1, 1, "even_07");
  endtask

  task automatic test_two_stop();
    run_frame(3, 8'hFF, 0, 2, "stop2_ff");
  endtask

  task automatic test_back_to_back();
    @(posedge clk_in); #1;
    tx_data = 8'h01;
    vld[0]  = 1'b1;
    @(posedge clk_in); #1;
    tx_data = 8'h80;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      n_assert++;
      if (tx_o[0] !== exp_tx(8'h01, 0, k)) begin
        n_fail++;
        $display("FAIL b2b_first tx cycle %0d: got %b expected %b", k, tx_o[0], exp_tx(8'h01, 0, k));
      end
    end
    @(negedge clk_in);
    n_assert++;
    if ({rdy_o[0], done_o[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_handover ready/done: got %b expected 11", {rdy_o[0], done_o[0]});
    end
    @(posedge clk_in); #1;
    vld[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      n_assert++;
      if (tx_o[0] !== exp_tx(8'h80, 0, k)) begin
        n_fail++;
        $display("FAIL b2b_second tx cycle %0d: got %b expected %b", k, tx_o[0], exp_tx(8'h80, 0, k));
      end
    end
    @(negedge clk_in);
    n_assert++;
    if ({rdy_o[0], done_o[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_second_done ready/done: got %b expected 11", {rdy_o[0], done_o[0]});
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(posedge clk_in); #1;
    tx_data = 8'h3C;
    vld[0]  = 1'b1;
    @(posedge clk_in); #1;
    vld[0]  = 1'b0;
    // Data bit 3 occupies cycles 17..20.
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_in);
      n_assert++;
      if (tx_o[0] !== exp_tx(8'h3C, 0, k)) begin
        n_fail++;
        $display("FAIL mid_rst_pre tx cycle %0d: got %b expected %b", k, tx_o[0], exp_tx(8'h3C, 0, k));
      end
    end
    rst_n = 1'b0;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    @(negedge clk_in);
    n_assert++;
    if ({tx_o[0], rdy_o[0], busy_o[0]} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_rst tx/ready/busy: got %b expected 110", {tx_o[0], rdy_o[0], busy_o[0]});
    end
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (done_o[0] === 1'b1 || tx_o[0] !== 1'b1) seen_done = 1'b1;
    end
    n_assert++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_no_done: got activity %b expected 0", seen_done);
    end
    run_frame(0, 8'h55, 0, 1, "post_rst_55");
  endtask

  task automatic test_hold_off();
    int len;
    len = frame_len(1, 1);
    @(posedge clk_in); #1;
    tx_data = 8'hA5;
    vld[1]  = 1'b1;
    @(posedge clk_in); #1;
    vld[1]  = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_in);
      n_assert++;
      if (tx_o[1] !== exp_tx(8'hA5, 1, k)) begin
        n_fail++;
        $display("FAIL holdoff tx cycle %0d: got %b expected %b", k, tx_o[1], exp_tx(8'hA5, 1, k));
      end
      if (k == 10) begin
        tx_data = 8'h00;
        vld[1]  = 1'b1;
      end
      if (k == 13) vld[1] = 1'b0;
      if (k == 30) tx_data = 8'hFF;
    end
    @(negedge clk_in);
    n_assert++;
    if ({rdy_o[1], done_o[1]} !== 2'b11) begin
      n_fail++;
      $display("FAIL holdoff_done ready/done: got %b expected 11", {rdy_o[1], done_o[1]});
    end
    repeat (2) @(negedge clk_in);
    n_assert++;
    if ({busy_o[1], tx_o[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL holdoff_no_extra busy/tx: got %b expected 01", {busy_o[1], tx_o[1]});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
    test_hold_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serialises one 8-bit byte per frame onto the UART transmit line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits directly downstream of the clock-divider stage and consumes its output rate.
- Bit timing is an internal clock-enable tick in the same clk_in domain; no derived clock is used as a clock.
- Upstream byte source hands bytes over via a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 16, clk_in cycles per serial bit; legal range 2..2^16-1.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has a byte on tx_data.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- tx  output  1  serial line; idle-high.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (rst_n low at a clk_in edge): state IDLE, tx=1, tx_busy=0, tx_done=0, bit counters cleared. tx_ready follows state, so it reads 1 during reset, but the handshake is ignored while rst_n=0.
- Handshake: a byte is accepted on an edge where tx_valid=1, tx_ready=1 and rst_n=1. tx_data is latched into the shift register on that edge. Changes to tx_data afterwards have no effect.
- Latency: tx falls low on the first cycle after the accepting edge.
- Each bit holds tx stable for exactly CLKS_PER_BIT cycles. The baud counter restarts at 0 on acceptance and wraps at CLKS_PER_BIT-1, where it emits the bit-advance tick.
- FSM states and transitions:
  - IDLE: tx=1. On handshake -> START.
  - START: tx=0 for one bit -> DATA.
  - DATA: tx = shift_reg[0]; shift right on each tick; 8 bits. -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: tx = XOR of latched byte (even), or its inverse (odd), for one bit -> STOP.
  - STOP: tx=1 for STOP_BITS bits -> IDLE.
- Exit from STOP: on the edge entering IDLE, tx_done=1 for exactly one cycle and tx_ready=1 in that same cycle.
- Back-to-back frames: if tx_valid is high in that cycle, the next byte is accepted and its start bit begins the following cycle. There is no extra idle bit between frames.
- Frame length in cycles = CLKS_PER_BIT * (10 + (PARITY!=0) + (STOP_BITS-1)).
- Reset mid-frame: at the next edge tx=1 and state returns to IDLE. The partial frame is abandoned and no tx_done is generated.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit index is 3 bits; it counts 0..7 in DATA and is reused for stop-bit count.
  - No counter may overflow past its terminal value.
- tx is registered, so it is glitch-free.
- tx_valid while busy is held off (tx_ready=0); upstream must keep tx_valid asserted until accepted.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - Frame data width constant UART_DATA_BITS=8.
- One sub-module: uart_baud_tick (parameter CLKS_PER_BIT; ports clk_in, rst_n, clear, tick). Emits a one-cycle tick every CLKS_PER_BIT cycles; clear restarts the count at 0.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 -> tx low 4 cycles from the cycle after accept; data bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles. tx_done pulses at cycle 40 after accept; tx_ready=0 throughout the frame.
- Same config with PARITY=1 (even) and 0xA5 -> parity bit 0; PARITY=2 (odd) -> parity bit 1. Frame is 44 cycles.
- STOP_BITS=2 with 0xFF -> start 0, eight 1s, stop high 8 cycles; tx_done at cycle 44; tx_busy high for the whole 44 cycles.
- tx_valid held high with 0x01 then 0x80 queued -> second start bit begins on the cycle after the first tx_done. No idle gap; both frames decode correctly.
- rst_n pulsed low during DATA bit 3 of 0x3C -> tx=1 and tx_ready=1 at the next edge; no tx_done. A new byte 0x55 sent afterwards transmits a full correct frame.
- tx_data changed mid-frame, and tx_valid pulsed while busy -> transmitted bits match the originally latched byte; no extra acceptance occurs.
